// File: rtl/arb_rr_fifo_rd.sv
// arb_rr_fifo_rd
//
// Round-robin read arbiter that drains NUM_CH upstream sync_fifo instances
// (1-cycle read latency, registered empty) onto one valid/ready stream.
// At most one FIFO is popped per cycle, and only when the 2-entry output
// buffer has room for the word. Room counts both the words already in the
// buffer and the word still in flight from the FIFO.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   fifoEmptyIn   per-channel empty flags from the FIFOs
//   fifoRdEnOut   per-channel pop strobes (at most one high)
//   fifoRdDataIn  packed FIFO read data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   outValid      output word valid
//   outReady      downstream accepts the word
//   outData       output word (buffer head)
//   outCh         source channel of outData
//   busy          a pop is in flight or the buffer holds data
//
// Handshake: a word moves downstream on every rising edge where outValid and
// outReady are both high. outValid never depends on outReady. While outValid
// is high and outReady is low, outData and outCh hold their values.
module arb_rr_fifo_rd #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CH_WIDTH   = $clog2(NUM_CH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            fifoEmptyIn,
  output logic [NUM_CH-1:0]            fifoRdEnOut,
  input  logic [NUM_CH*DATA_WIDTH-1:0] fifoRdDataIn,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [DATA_WIDTH-1:0]        outData,
  output logic [CH_WIDTH-1:0]          outCh,
  output logic                         busy
);

  logic [CH_WIDTH-1:0]   last_gnt;
  logic                  inflight;
  logic [CH_WIDTH-1:0]   inflight_ch;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [CH_WIDTH-1:0]   buf_ch [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            occ;

  logic [NUM_CH-1:0]     req;
  logic [2:0]            pend;
  logic                  pop_out;
  logic                  credit;
  logic                  gnt_found;
  logic [CH_WIDTH-1:0]   gnt_idx;
  logic                  gnt_valid;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;

  assign req     = ~fifoEmptyIn;
  assign pend    = {1'b0, occ} + {2'b0, inflight};
  assign pop_out = outValid && outReady;
  // A full pipeline (buffer + in-flight word == 2) may still pop when the
  // head leaves this cycle; this keeps one word per cycle in steady state.
  assign credit  = (pend < 3'd2) || ((pend == 3'd2) && pop_out);

  // Search lastGnt+1, lastGnt+2, ... modulo NUM_CH for the first requester.
  always_comb begin : grant_search
    int                  cand_i;
    logic [CH_WIDTH-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_i    = 0;
    cand      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand_i = int'(last_gnt) + i;
      if (cand_i >= NUM_CH) cand_i = cand_i - NUM_CH;
      cand = CH_WIDTH'(cand_i);
      if (!gnt_found && req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Gated by reset so that no FIFO is popped while the block is held in reset.
  assign gnt_valid = reset && credit && gnt_found;

  always_comb begin
    fifoRdEnOut = '0;
    if (gnt_valid) fifoRdEnOut[gnt_idx] = 1'b1;
  end

  // The word popped last cycle is on the FIFO's read port now.
  assign push = inflight;

  always_comb begin
    push_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (inflight_ch == CH_WIDTH'(c)) push_data = fifoRdDataIn[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_gnt    <= CH_WIDTH'(NUM_CH - 1);
      inflight    <= 1'b0;
      inflight_ch <= '0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_ch[0]   <= '0;
      buf_ch[1]   <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      occ         <= 2'd0;
    end else begin
      if (gnt_valid) begin
        last_gnt    <= gnt_idx;
        inflight_ch <= gnt_idx;
      end
      inflight <= gnt_valid;
      if (push) begin
        buf_data[wr_ptr] <= push_data;
        buf_ch[wr_ptr]   <= inflight_ch;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop_out) rd_ptr <= ~rd_ptr;
      case ({push, pop_out})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign outValid = (occ != 2'd0);
  assign outData  = buf_data[rd_ptr];
  assign outCh    = buf_ch[rd_ptr];
  assign busy     = inflight || outValid;

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset) pend <= 3'd2);
  a_rd_en_onehot: assert property (@(posedge clock) disable iff (!reset) $onehot0(fifoRdEnOut));

endmodule

// File: tb/tb_arb_rr_fifo_rd.sv
// Testbench for arb_rr_fifo_rd: upstream sync_fifo models (registered empty,
// 1-cycle read latency), a scoreboard of expected {ch, data} words, and
// directed scenarios for reset, single channel, fairness, backpressure,
// skipping empty channels and reset in mid-stream.
module tb_arb_rr_fifo_rd;
  localparam int NUM_CH = 4;
  localparam int DW     = 8;
  localparam int CW     = 2;
  localparam int W      = CW + DW;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [NUM_CH-1:0]    fifo_empty   = '1;
  logic [NUM_CH-1:0]    rd_en;
  logic [NUM_CH*DW-1:0] fifo_rd_data = '0;
  logic                 out_valid;
  logic                 out_ready    = 1'b0;
  logic [DW-1:0]        out_data;
  logic [CW-1:0]        out_ch;
  logic                 busy;

  arb_rr_fifo_rd #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .fifoEmptyIn  (fifo_empty),
    .fifoRdEnOut  (rd_en),
    .fifoRdDataIn (fifo_rd_data),
    .outValid     (out_valid),
    .outReady     (out_ready),
    .outData      (out_data),
    .outCh        (out_ch),
    .busy         (busy)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- upstream FIFO models ----------------
  logic [DW-1:0] fq [NUM_CH][$];
  int            pop_cnt [NUM_CH];

  always @(posedge clock) begin
    if (rd_en != '0) check("rd_en_onehot", $countones(rd_en), 1);
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_en[i]) begin
        check("no_underflow", fq[i].size() != 0, 1);
        if (fq[i].size() != 0) fifo_rd_data[i*DW +: DW] <= fq[i].pop_front();
        pop_cnt[i] = pop_cnt[i] + 1;
      end
      fifo_empty[i] <= (fq[i].size() == 0);
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      check("word_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("word", {out_ch, out_data}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic release_reset();
    tick();
    reset = 1'b1;
  endtask

  task automatic load(input int ch, input logic [DW-1:0] d, input bit expect_it);
    fq[ch].push_back(d);
    if (expect_it) exp_q.push_back({CW'(ch), d});
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid_seen"}, out_valid, 1);
  endtask

  // Expect n words on n consecutive cycles, then an empty buffer.
  task automatic stream(input int n, input string tag);
    wait_valid(tag);
    for (int k = 0; k < n; k++) begin
      check({tag, "_consecutive"}, out_valid, 1);
      tick();
    end
    check({tag, "_end"}, out_valid, 0);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scenarios ----------------
  initial begin
    int base1, base2, base;
    int n;

    // Reset check: all channels non-empty while reset held for 30 cycles.
    out_ready = 1'b1;
    reset     = 1'b0;
    for (int c = 0; c < NUM_CH; c++) load(c, 8'(8'h30 + c), 1'b1);
    for (int k = 0; k < 30; k++) begin
      tick();
      if (k % 10 == 9) check("reset_outputs", {rd_en, out_valid, out_data, out_ch, busy}, 0);
    end
    release_reset();
    #2;
    check("first_pop_ch0", rd_en, 4'b0001);
    stream(4, "reset_drain");

    // Single channel: ch2 holds 0x00..0x13.
    hold_reset();
    base = pop_cnt[2];
    for (int k = 0; k < 20; k++) load(2, 8'(k), 1'b1);
    release_reset();
    stream(20, "single");
    check("single_pops", pop_cnt[2] - base, 20);

    // Fairness: 4 channels x 8 words, expect 0,1,2,3 repeated.
    hold_reset();
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < 8; k++) load(c, 8'(c * 16 + k), 1'b0);
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < NUM_CH; c++) exp_q.push_back({CW'(c), 8'(c * 16 + k)});
    release_reset();
    stream(32, "fair");

    // Backpressure: ch1 holds 10 words, outReady low for 20 cycles.
    out_ready = 1'b0;
    hold_reset();
    base = pop_cnt[1];
    for (int k = 0; k < 10; k++) load(1, 8'(8'h50 + k), 1'b1);
    release_reset();
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid) check("bp_hold_data", out_data, 8'h50);
    end
    check("bp_pops", pop_cnt[1] - base, 2);
    check("bp_valid", out_valid, 1);
    check("bp_ch", out_ch, 1);
    out_ready = 1'b1;
    stream(10, "bp_release");
    check("bp_total_pops", pop_cnt[1] - base, 10);

    // Skip empty: only ch0 and ch3 hold data.
    hold_reset();
    base1 = pop_cnt[1];
    base2 = pop_cnt[2];
    for (int k = 0; k < 4; k++) begin
      load(0, 8'(8'h60 + k), 1'b0);
      load(3, 8'(8'h70 + k), 1'b0);
      exp_q.push_back({2'd0, 8'(8'h60 + k)});
      exp_q.push_back({2'd3, 8'(8'h70 + k)});
    end
    release_reset();
    stream(8, "skip");
    check("skip_ch1_unread", pop_cnt[1] - base1, 0);
    check("skip_ch2_unread", pop_cnt[2] - base2, 0);

    // Reset in mid-stream, the cycle after a pop on ch1.
    hold_reset();
    for (int k = 0; k < 4; k++) load(1, 8'(8'h80 + k), 1'b0);
    release_reset();
    #1;
    n = 0;
    while (!rd_en[1] && n < 20) begin
      tick();
      n++;
    end
    check("mid_pop_seen", rd_en[1], 1);
    tick();
    reset = 1'b0;
    #1;
    check("mid_reset_clear", {rd_en, out_valid, out_data, out_ch}, 0);
    check("mid_busy", busy, 0);
    exp_q.delete();
    // The in-flight word 0x80 is lost; the remaining ch1 words follow ch0.
    load(0, 8'hA0, 1'b1);
    exp_q.push_back({2'd1, 8'h81});
    exp_q.push_back({2'd1, 8'h82});
    exp_q.push_back({2'd1, 8'h83});
    repeat (2) tick();
    release_reset();
    #2;
    check("resume_ch0", rd_en, 4'b0001);
    stream(4, "mid_resume");

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
